// File: rtl/dct_pkg.sv
// Shared constants, row-scheduler state encoding, the buffered output-row record
// and the odd-part coefficient table of the 8-point DCT-II.
package dct_pkg;

    localparam int DCT_IN_W = 18;
    localparam int DCT_E_W  = 19;
    localparam int DCT_O_W  = 27;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_e;

    typedef struct packed {
        logic [3:0][DCT_E_W-1:0] ye;
        logic [3:0][DCT_O_W-1:0] yo;
        logic [2:0]              row;
        logic                    sop;
        logic                    eop;
        logic                    tskip;
    } dct_row_t;

    // Row k of the odd matrix applied to the differences X[n]-X[7-n].
    function automatic logic signed [7:0] dct8_odd_coef(input logic [1:0] k, input logic [1:0] n);
        logic signed [7:0] c;
        case ({k, n})
            4'h0:    c =  8'sd89;
            4'h1:    c =  8'sd75;
            4'h2:    c =  8'sd50;
            4'h3:    c =  8'sd18;
            4'h4:    c =  8'sd75;
            4'h5:    c = -8'sd18;
            4'h6:    c = -8'sd89;
            4'h7:    c = -8'sd50;
            4'h8:    c =  8'sd50;
            4'h9:    c = -8'sd89;
            4'hA:    c =  8'sd18;
            4'hB:    c =  8'sd75;
            4'hC:    c =  8'sd18;
            4'hD:    c = -8'sd50;
            4'hE:    c =  8'sd75;
            4'hF:    c = -8'sd89;
            default: c =  8'sd0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dct2_8.sv
// Combinational 8-point DCT-II first stage: even sums E[i] = X[i]+X[7-i] and the
// four odd coefficients from the differences, at full precision.
module dct2_8
    import dct_pkg::*;
(
    input  logic signed [DCT_IN_W-1:0] x  [0:7],
    output logic signed [DCT_E_W-1:0]  ye [0:3],
    output logic signed [DCT_O_W-1:0]  yo [0:3]
);

    logic signed [DCT_E_W-1:0] od_s  [0:3];
    logic signed [DCT_O_W-1:0] acc_s;

    // Butterfly then the 4x4 odd matrix; 232*(2^18-1) still fits in 27 signed bits.
    always_comb begin
        acc_s = '0;
        for (int i = 0; i < 4; i++) begin
            ye[i]   = DCT_E_W'(x[i]) + DCT_E_W'(x[7 - i]);
            od_s[i] = DCT_E_W'(x[i]) - DCT_E_W'(x[7 - i]);
        end
        for (int k = 0; k < 4; k++) begin
            acc_s = '0;
            for (int n = 0; n < 4; n++) begin
                acc_s = acc_s + DCT_O_W'(od_s[n]) * DCT_O_W'(dct8_odd_coef(2'(k), 2'(n)));
            end
            yo[k] = acc_s;
        end
    end

endmodule

// File: rtl/dct_row_fifo.sv
// Two-entry FIFO of output rows; a push and pop together at count 1 replaces the head.
module dct_row_fifo
    import dct_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  dct_row_t   din,
    output dct_row_t   dout,
    output logic [1:0] count
);

    dct_row_t   mem_q [0:1];
    dct_row_t   mem_d [0:1];
    logic       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_push_s, do_pop_s;

    assign do_push_s = push && (count_q != 2'd2);
    assign do_pop_s  = pop && (count_q != 2'd0);
    assign dout      = mem_q[rd_ptr_q];
    assign count     = count_q;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared on reset so the head reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/dct2_8_row_sched.sv
// Row scheduler feeding one dct2_8 and buffering results in a 2-entry FIFO with
// row/block tags. Define DCT8_TSKIP_EN to add the per-row transform-skip bypass.
module dct2_8_row_sched
    import dct_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_sop,
    input  logic signed [DCT_IN_W-1:0] in_x [0:7],
`ifdef DCT8_TSKIP_EN
    input  logic                       in_tskip,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [DCT_E_W-1:0]  out_ye [0:3],
    output logic signed [DCT_O_W-1:0]  out_yo [0:3],
    output logic [2:0]                 out_row,
    output logic                       out_sop,
    output logic                       out_eop,
    output logic                       busy,
    output logic                       err
);

    sched_state_e              state_q, state_d;
    logic [2:0]                row_cnt_q, row_cnt_d;
    logic                      err_q, err_d;
    logic                      accept_s, push_s, pop_s, tskip_s, unused_tskip_s;
    logic [1:0]                count_s;
    dct_row_t                  push_row_s, head_s;
    logic signed [DCT_E_W-1:0] dct_ye_s [0:3];
    logic signed [DCT_O_W-1:0] dct_yo_s [0:3];

    dct2_8 u_dct (
        .x  (in_x),
        .ye (dct_ye_s),
        .yo (dct_yo_s)
    );

    dct_row_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (push_row_s),
        .dout  (head_s),
        .count (count_s)
    );

`ifdef DCT8_TSKIP_EN
    assign tskip_s = in_tskip;
`else
    assign tskip_s = 1'b0;
`endif

    assign in_ready       = int'(count_s) < FIFO_DEPTH;
    assign accept_s       = in_valid && in_ready;
    assign out_valid      = (count_s != 2'd0);
    assign pop_s          = out_valid && out_ready;
    assign busy           = (state_q == ST_RUN) || (count_s != 2'd0);
    assign err            = err_q;
    assign unused_tskip_s = head_s.tskip;

    // Framing: build the tagged row to push and the next row counter.
    always_comb begin
        state_d          = state_q;
        row_cnt_d        = row_cnt_q;
        err_d            = 1'b0;
        push_s           = 1'b0;
        push_row_s       = '0;
        push_row_s.tskip = tskip_s;
        for (int i = 0; i < 4; i++) begin
            push_row_s.ye[i] = tskip_s ? DCT_E_W'(in_x[i])     : dct_ye_s[i];
            push_row_s.yo[i] = tskip_s ? DCT_O_W'(in_x[4 + i]) : dct_yo_s[i];
        end
        if (accept_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_sop) begin
                        push_s         = 1'b1;
                        push_row_s.sop = 1'b1;
                        row_cnt_d      = 3'd1;
                        state_d        = ST_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    push_s = 1'b1;
                    if (in_sop) begin
                        // Abandon the open block; this row restarts at row 0.
                        err_d          = 1'b1;
                        push_row_s.sop = 1'b1;
                        row_cnt_d      = 3'd1;
                    end else begin
                        push_row_s.row = row_cnt_q;
                        push_row_s.eop = (row_cnt_q == 3'd7);
                        row_cnt_d      = row_cnt_q + 3'd1;
                        if (row_cnt_q == 3'd7) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    row_cnt_d = 3'd0;
                end
            endcase
        end else begin
            push_s = 1'b0;
        end
    end

    // Output fields come straight from the FIFO head register.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            out_ye[i] = head_s.ye[i];
            out_yo[i] = head_s.yo[i];
        end
        out_row = head_s.row;
        out_sop = head_s.sop;
        out_eop = head_s.eop;
    end

    // Scheduler state, row counter and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            row_cnt_q <= 3'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_dct2_8_row_sched.sv
// Self-checking bench for dct2_8_row_sched: directed scenarios plus a randomized
// run against a queue-based reference model of the row/block behaviour.
module tb_dct2_8_row_sched;

    typedef logic [7:0][17:0] xrow_t;
    typedef struct packed {
        xrow_t      x;
        logic [2:0] row;
        logic       sop;
        logic       eop;
        logic       ts;
    } exp_row_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, in_valid, in_ready, in_sop, out_valid, out_ready;
    logic signed [17:0] in_x   [0:7];
    logic signed [18:0] out_ye [0:3];
    logic signed [26:0] out_yo [0:3];
    logic [2:0]         out_row;
    logic               out_sop, out_eop, busy, err;
`ifdef DCT8_TSKIP_EN
    logic               in_tskip = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int coef [4][4] = '{'{89, 75, 50, 18}, '{75, -18, -89, -50},
                        '{50, -89, 18, 75}, '{18, -50, 75, -89}};

    dct2_8_row_sched dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop),
        .in_x(in_x),
`ifdef DCT8_TSKIP_EN
        .in_tskip(in_tskip),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_ye(out_ye), .out_yo(out_yo),
        .out_row(out_row), .out_sop(out_sop), .out_eop(out_eop), .busy(busy), .err(err)
    );

    function automatic longint ref_ye(input xrow_t x, input int i, input logic ts);
        if (ts) return longint'($signed(x[i]));
        return longint'($signed(x[i])) + longint'($signed(x[7 - i]));
    endfunction

    function automatic longint ref_yo(input xrow_t x, input int k, input logic ts);
        longint s = 0;
        if (ts) return longint'($signed(x[4 + k]));
        for (int j = 0; j < 4; j++)
            s += longint'(coef[k][j]) * (longint'($signed(x[j])) - longint'($signed(x[7 - j])));
        return s;
    endfunction

    function automatic xrow_t rand_row();
        xrow_t r;
        for (int j = 0; j < 8; j++) begin
            case ($urandom_range(0, 7))
                0:       r[j] = 18'h1FFFF;
                1:       r[j] = 18'h20000;
                default: r[j] = 18'($urandom);
            endcase
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_row(input xrow_t v, input logic sop);
        in_valid = 1'b1;
        in_sop   = sop;
        for (int j = 0; j < 8; j++) in_x[j] = v[j];
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; out_ready = 1'b1;
        for (int j = 0; j < 8; j++) in_x[j] = 18'sd0;
        tick(); tick();
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if ({out_valid, busy, err, out_sop, out_eop, out_row} !== 8'd0) begin
            n_errors++; $display("FAIL reset_outputs: got v%b b%b e%b s%b e%b r%0d want all 0", out_valid, busy, err, out_sop, out_eop, out_row); end
        n_checks++; if (out_ye[0] !== 19'sd0 || out_yo[3] !== 27'sd0) begin
            n_errors++; $display("FAIL reset_data: got ye0 %0d yo3 %0d want 0", out_ye[0], out_yo[3]); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ones();
        xrow_t ones;
        for (int j = 0; j < 8; j++) ones[j] = 18'd1;
        out_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            set_row(ones, r == 0);
            tick();
            n_checks++; if (out_valid !== 1'b1 || out_row !== 3'(r)) begin
                n_errors++; $display("FAIL ones_row: got valid %b row %0d want 1 %0d", out_valid, out_row, r); end
            n_checks++; if (out_sop !== (r == 0) || out_eop !== (r == 7)) begin
                n_errors++; $display("FAIL ones_tags row %0d: got sop %b eop %b", r, out_sop, out_eop); end
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (out_ye[i] !== 19'sd2 || out_yo[i] !== 27'sd0) begin
                    n_errors++; $display("FAIL ones_data row %0d i %0d: got ye %0d yo %0d want 2 0", r, i, out_ye[i], out_yo[i]); end
            end
        end
        in_valid = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_errors++; $display("FAIL ones_drain: got valid %b busy %b want 0 0", out_valid, busy); end
    endtask

    task automatic test_values();
        xrow_t xv;
        int    e_yo [4] = '{89, 75, 50, 18};
        xv = '0; xv[0] = 18'd1;
        out_ready = 1'b1;
        set_row(xv, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (out_ye[i] !== ((i == 0) ? 19'sd1 : 19'sd0) || out_yo[i] !== 27'(e_yo[i])) begin
                n_errors++; $display("FAIL impulse i %0d: got ye %0d yo %0d want %0d %0d", i, out_ye[i], out_yo[i], (i == 0), e_yo[i]); end
        end
        for (int j = 0; j < 8; j++) xv[j] = (j < 4) ? 18'h1FFFF : 18'h20000;
        set_row(xv, 1'b0);
        tick();
        n_checks++; if (out_yo[0] !== 27'sd60817176) begin
            n_errors++; $display("FAIL extreme_yo0: got %0d want 60817176", out_yo[0]); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (out_ye[i] !== -19'sd1 || out_yo[i] !== ref_yo(xv, i, 1'b0)) begin
                n_errors++; $display("FAIL extreme i %0d: got ye %0d yo %0d want -1 %0d", i, out_ye[i], out_yo[i], ref_yo(xv, i, 1'b0)); end
        end
        for (int r = 2; r < 8; r++) begin
            xv = rand_row();
            set_row(xv, 1'b0);
            tick();
            n_checks++; if (out_row !== 3'(r) || out_eop !== (r == 7)) begin
                n_errors++; $display("FAIL values_tags: got row %0d eop %b want %0d", out_row, out_eop, r); end
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (out_ye[i] !== ref_ye(xv, i, 1'b0) || out_yo[i] !== ref_yo(xv, i, 1'b0)) begin
                    n_errors++; $display("FAIL values_data row %0d i %0d: got %0d %0d want %0d %0d", r, i,
                        out_ye[i], out_yo[i], ref_ye(xv, i, 1'b0), ref_yo(xv, i, 1'b0)); end
            end
        end
        in_valid = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL values_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        xrow_t x0, x1;
        x0 = rand_row(); x1 = rand_row();
        out_ready = 1'b0;
        set_row(x0, 1'b1);
        tick();
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            n_errors++; $display("FAIL bp_one: got ready %b valid %b want 1 1", in_ready, out_valid); end
        set_row(x1, 1'b0);
        tick();
        set_row(rand_row(), 1'b0);
        for (int c = 0; c < 3; c++) begin
            n_checks++; if (in_ready !== 1'b0 || out_row !== 3'd0 || out_ye[0] !== ref_ye(x0, 0, 1'b0)) begin
                n_errors++; $display("FAIL bp_hold cyc %0d: got ready %b row %0d ye0 %0d want 0 0 %0d", c, in_ready, out_row, out_ye[0], ref_ye(x0, 0, 1'b0)); end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++; if (in_ready !== 1'b1 || out_row !== 3'd1 || out_yo[0] !== ref_yo(x1, 0, 1'b0)) begin
            n_errors++; $display("FAIL bp_release: got ready %b row %0d yo0 %0d want 1 1 %0d", in_ready, out_row, out_yo[0], ref_yo(x1, 0, 1'b0)); end
        out_ready = 1'b1;
        for (int r = 2; r < 8; r++) begin set_row(rand_row(), 1'b0); tick(); end
        in_valid = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_errors++; $display("FAIL bp_drain: got busy %b valid %b want 0 0", busy, out_valid); end
    endtask

    task automatic test_framing();
        out_ready = 1'b1;
        set_row(rand_row(), 1'b0);
        tick();
        n_checks++; if (err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_errors++; $display("FAIL idle_nosop: got err %b valid %b busy %b want 1 0 0", err, out_valid, busy); end
        in_valid = 1'b0;
        tick();
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL idle_err_pulse: got %b want 0", err); end
        for (int r = 0; r < 3; r++) begin set_row(rand_row(), r == 0); tick(); end
        set_row(rand_row(), 1'b1);
        tick();
        n_checks++; if (err !== 1'b1 || out_row !== 3'd0 || out_sop !== 1'b1 || out_eop !== 1'b0) begin
            n_errors++; $display("FAIL midsop: got err %b row %0d sop %b eop %b want 1 0 1 0", err, out_row, out_sop, out_eop); end
        for (int r = 1; r < 8; r++) begin
            set_row(rand_row(), 1'b0);
            tick();
            n_checks++; if (err !== 1'b0 || out_row !== 3'(r) || out_eop !== (r == 7)) begin
                n_errors++; $display("FAIL midsop_tail: got err %b row %0d eop %b want 0 %0d", err, out_row, out_eop, r); end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin set_row(rand_row(), r == 0); tick(); end
        out_ready = 1'b0;
        set_row(rand_row(), 1'b0);
        tick();
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL rstmid_full: got ready %b want 0", in_ready); end
        rst = 1'b1; in_valid = 1'b0;
        tick();
        rst = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0) begin
            n_errors++; $display("FAIL rstmid_state: got valid %b busy %b ready %b err %b want 0 0 1 0", out_valid, busy, in_ready, err); end
        out_ready = 1'b1;
        set_row(rand_row(), 1'b1);
        tick();
        n_checks++; if (out_row !== 3'd0 || out_sop !== 1'b1 || err !== 1'b0) begin
            n_errors++; $display("FAIL rstmid_restart: got row %0d sop %b err %b want 0 1 0", out_row, out_sop, err); end
        for (int r = 1; r < 8; r++) begin set_row(rand_row(), 1'b0); tick(); end
        in_valid = 1'b0;
        tick();
    endtask

`ifdef DCT8_TSKIP_EN
    task automatic test_tskip();
        xrow_t xv;
        for (int j = 0; j < 8; j++) xv[j] = 18'(j + 1);
        out_ready = 1'b1; in_tskip = 1'b1;
        set_row(xv, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (out_ye[i] !== 19'(i + 1) || out_yo[i] !== 27'(i + 5)) begin
                n_errors++; $display("FAIL tskip i %0d: got %0d %0d want %0d %0d", i, out_ye[i], out_yo[i], i + 1, i + 5); end
        end
        in_tskip = 1'b0;
        for (int r = 1; r < 8; r++) begin set_row(rand_row(), 1'b0); tick(); end
        in_valid = 1'b0;
        tick();
    endtask
`endif

    task automatic test_random();
        exp_row_t q[$];
        exp_row_t e, h;
        logic     in_blk = 1'b0, err_exp = 1'b0, acc, pop, ts;
        int       nxt = 0;
        rst = 1'b1; in_valid = 1'b0;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 800; c++) begin
            e.x   = rand_row();
            e.sop = in_blk ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) != 0);
            ts    = 1'b0;
`ifdef DCT8_TSKIP_EN
            ts       = $urandom_range(0, 3) == 0;
            in_tskip = ts;
`endif
            set_row(e.x, e.sop);
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            n_checks++; if (in_ready !== (q.size() < 2) || out_valid !== (q.size() != 0)) begin
                n_errors++; $display("FAIL rnd_hs cyc %0d: got ready %b valid %b, model count %0d", c, in_ready, out_valid, q.size()); end
            n_checks++; if (err !== err_exp || busy !== (in_blk || q.size() != 0)) begin
                n_errors++; $display("FAIL rnd_flags cyc %0d: got err %b busy %b want %b %b", c, err, busy, err_exp, in_blk || q.size() != 0); end
            if (q.size() != 0) begin
                h = q[0];
                n_checks++; if (out_row !== h.row || out_sop !== h.sop || out_eop !== h.eop) begin
                    n_errors++; $display("FAIL rnd_tags cyc %0d: got %0d %b %b want %0d %b %b", c, out_row, out_sop, out_eop, h.row, h.sop, h.eop); end
                for (int i = 0; i < 4; i++) begin
                    n_checks++; if (out_ye[i] !== ref_ye(h.x, i, h.ts) || out_yo[i] !== ref_yo(h.x, i, h.ts)) begin
                        n_errors++; $display("FAIL rnd_data cyc %0d i %0d: got %0d %0d want %0d %0d", c, i,
                            out_ye[i], out_yo[i], ref_ye(h.x, i, h.ts), ref_yo(h.x, i, h.ts)); end
                end
            end
            acc = in_valid && (q.size() < 2);
            pop = out_ready && (q.size() != 0);
            tick();
            err_exp = 1'b0;
            if (pop) void'(q.pop_front());
            if (acc) begin
                e.ts = ts; e.eop = 1'b0; e.row = 3'd0;
                if (e.sop) begin
                    err_exp = in_blk;
                    in_blk  = 1'b1;
                    nxt     = 1;
                    q.push_back(e);
                end else if (in_blk) begin
                    e.row = 3'(nxt);
                    e.eop = (nxt == 7);
                    if (nxt == 7) in_blk = 1'b0;
                    nxt++;
                    q.push_back(e);
                end else begin
                    err_exp = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ones();
        test_values();
        test_backpressure();
        test_framing();
        test_reset_mid();
`ifdef DCT8_TSKIP_EN
        test_tskip();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
